// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, default frame geometry
// and the parity helper used by both the transmitter and receiver.
package uart_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int MAX_DATA_W     = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } tx_state_t;

    // Callers zero-extend narrower payloads; extra zeros leave the XOR unchanged.
    function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data,
                                         input logic                  odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tick_detect.sv
// Rising-edge detector for the baud generator square wave. Produces a
// registered one-clk tick per rising edge of baud_in.
module uart_tick_detect (
    input  logic clk,
    input  logic rst,
    input  logic baud_in,
    output logic tick
);

    logic baud_q;

    // tick is registered so downstream logic never sees a combinational path from baud_in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_q <= 1'b0;
            tick   <= 1'b0;
        end else begin
            baud_q <= baud_in;
            tick   <= baud_in & ~baud_q;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts bytes over valid/ready, serialises them LSB-first
// with start bit, optional parity and one or two stop bits on the tick grid.
//
// Handshake: a byte is accepted on the clk edge where tx_valid && tx_ready;
// tx_ready is high only in IDLE, and tx_valid while tx_ready is low is ignored.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_in,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic              stop2,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              tx_busy,
    output logic              tx_done,
    output tx_state_t         dbg_state
);

    localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    logic tick;

    uart_tick_detect u_tick (
        .clk     (clk),
        .rst     (rst),
        .baud_in (baud_in),
        .tick    (tick)
    );

    tx_state_t         state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [IDX_W-1:0]  bit_idx, idx_n;
    logic [DATA_W-1:0] shift, shift_n;
    logic              par_en_q, par_en_n;
    logic              stop2_q, stop2_n;
    logic              par_bit_q, par_bit_n;
    logic              stop_idx, stop_idx_n;
    logic              out_n, ready_n, busy_n, done_n;
    logic              bit_end;

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            par_bit_q <= 1'b0;
            stop_idx  <= 1'b0;
            tx_out    <= 1'b1;
            tx_ready  <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= idx_n;
            shift     <= shift_n;
            par_en_q  <= par_en_n;
            stop2_q   <= stop2_n;
            par_bit_q <= par_bit_n;
            stop_idx  <= stop_idx_n;
            tx_out    <= out_n;
            tx_ready  <= ready_n;
            tx_busy   <= busy_n;
            tx_done   <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        idx_n      = bit_idx;
        shift_n    = shift;
        par_en_n   = par_en_q;
        stop2_n    = stop2_q;
        par_bit_n  = par_bit_q;
        stop_idx_n = stop_idx;
        done_n     = 1'b0;
        bit_end    = tick && (cnt == CNT_LAST);

        case (state)
            ST_IDLE: begin
                if (tx_valid && tx_ready) begin
                    state_n    = ST_ARM;
                    shift_n    = tx_data;
                    par_en_n   = parity_en;
                    stop2_n    = stop2;
                    // Parity is computed now because the shifter consumes the data.
                    par_bit_n  = calc_parity(MAX_DATA_W'(tx_data), parity_odd);
                    cnt_n      = '0;
                    idx_n      = '0;
                    stop_idx_n = 1'b0;
                end
            end
            ST_ARM: begin
                if (tick) begin
                    state_n = ST_START;
                    cnt_n   = '0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_n = ST_DATA;
                    idx_n   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_n = shift >> 1;
                    if (bit_idx == IDX_LAST) begin
                        state_n    = par_en_q ? ST_PARITY : ST_STOP;
                        stop_idx_n = 1'b0;
                    end else begin
                        idx_n = bit_idx + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_n    = ST_STOP;
                    stop_idx_n = 1'b0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_idx) begin
                        stop_idx_n = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // The in-bit tick counter only advances in the four bit-carrying states.
        if (tick && (state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP})) begin
            cnt_n = bit_end ? '0 : cnt + 1'b1;
        end

        case (state_n)
            ST_START:  out_n = 1'b0;
            ST_DATA:   out_n = shift_n[0];
            ST_PARITY: out_n = par_bit_n;
            default:   out_n = 1'b1;
        endcase
        ready_n = (state_n == ST_IDLE);
        busy_n  = (state_n != ST_IDLE);
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed and random frames compared
// cycle by cycle against a bit-sequence model in baud-time units.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int BIT_T = 64;  // baud period 4 clk x 16 ticks per bit

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_in = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       parity_en = 1'b0;
  logic       parity_odd = 1'b0;
  logic       stop2 = 1'b0;
  logic       tx_ready, tx_out, tx_busy, tx_done;
  tx_state_t  dbg_state;

  always #5 clk = ~clk;

  uart_tx #(.DATA_W(8), .OVERSAMPLE(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_in    (baud_in),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2      (stop2),
    .tx_ready   (tx_ready),
    .tx_out     (tx_out),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .dbg_state  (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- baud generator ----------------
  // vt counts baud-generator steps; vt_p2 is its value two clk back, which is
  // how far the DUT output lags the baud line.
  bit         baud_run = 1'b1;
  logic [1:0] phase = 2'd0;
  int         vt = 0, vt_p1 = 0, vt_p2 = 0;
  int         rise_cyc = -100;

  initial forever begin
    logic prev;
    @(posedge clk);
    #2;
    vt_p2 = vt_p1;
    vt_p1 = vt;
    if (baud_run) begin
      phase = phase + 2'd1;
      vt++;
    end
    prev    = baud_in;
    baud_in = phase[1];
    if (baud_in && !prev) rise_cyc = cyc;
  end

  // ---------------- reference model ----------------
  // Frame word: {stop2, parity_odd, parity_en, data}
  logic [10:0] exp_q[$];

  function automatic int frame_len(input logic [10:0] f);
    return 10 + int'(f[8]) + int'(f[10]);
  endfunction

  function automatic logic frame_bit(input logic [10:0] f, input int i);
    logic [7:0] d;
    logic       ones_odd;
    d = f[7:0];
    ones_odd = ($countones(d) % 2) != 0;
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (f[8] && i == 9) return ones_odd ^ f[9];
    return 1'b1;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  bit          in_frame = 1'b0;
  logic [10:0] cur = '0;
  int          start_vt = 0, flen = 0, pos = 0;
  int          frames_seen = 0;
  int          last_done_cyc = -100;
  int          last_accept_cyc = 0;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (tx_out == 1'b0) begin
        check_eq("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        cur = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        check_eq("start_after_rise", 32'(cyc - rise_cyc), 32'd2);
        check_eq("arm_wait", 32'((cyc - last_accept_cyc) inside {[1:4]}), 32'd1);
        in_frame = 1'b1;
        start_vt = vt_p2;
        flen     = frame_len(cur);
      end else begin
        check_eq("idle_done_low", 32'(tx_done), 32'd0);
      end
    end else begin
      pos = vt_p2 - start_vt;
      if (pos < flen * BIT_T) begin
        check_eq("tx_bit", 32'(tx_out), 32'(frame_bit(cur, pos / BIT_T)));
        check_eq("busy_in_frame", 32'(tx_busy), 32'd1);
        check_eq("ready_in_frame", 32'(tx_ready), 32'd0);
        check_eq("done_in_frame", 32'(tx_done), 32'd0);
      end else begin
        check_eq("end_done", 32'(tx_done), 32'd1);
        check_eq("end_busy", 32'(tx_busy), 32'd0);
        check_eq("end_ready", 32'(tx_ready), 32'd1);
        check_eq("end_out", 32'(tx_out), 32'd1);
        frames_seen++;
        last_done_cyc = cyc;
        in_frame = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  int sent = 0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic send(input logic [7:0] d, input bit pe, input bit po, input bit s2,
                      input bit hold, output int acc);
    bit rdy;
    int w;
    w = 0;
    tx_data = d;
    parity_en = pe;
    parity_odd = po;
    stop2 = s2;
    tx_valid = 1'b1;
    rdy = tx_ready;
    while (!rdy && w < 4000) begin
      step(1);
      w++;
      rdy = tx_ready;
    end
    check_eq("accept_timeout", 32'(rdy), 32'd1);
    step(1);
    acc = cyc;
    if (rdy) begin
      exp_q.push_back({s2, po, pe, d});
      sent++;
      last_accept_cyc = acc;
    end
    check_eq("ready_falls", 32'(tx_ready), 32'd0);
    check_eq("busy_rises", 32'(tx_busy), 32'd1);
    if (!hold) begin
      tx_valid = 1'b0;
      // Scramble inputs so a frame that fails to latch them shows up.
      tx_data = 8'($urandom);
      parity_en = 1'($urandom);
      parity_odd = 1'($urandom);
      stop2 = 1'($urandom);
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || in_frame) && w < 6000) begin
      step(1);
      w++;
    end
    check_eq("frame_timeout", 32'(w < 6000), 32'd1);
    step(3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc1, acc2;
    int aborted;
    aborted = 0;

    step(5);
    check_eq("rst_out", 32'(tx_out), 32'd1);
    check_eq("rst_ready", 32'(tx_ready), 32'd1);
    check_eq("rst_busy", 32'(tx_busy), 32'd0);
    check_eq("rst_done", 32'(tx_done), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b1;
    step(3);

    send(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, acc1);
    wait_idle();
    check_eq("ready_after_55", 32'(tx_ready), 32'd1);

    send(8'hA3, 1'b1, 1'b0, 1'b0, 1'b0, acc1);
    wait_idle();
    send(8'hA3, 1'b1, 1'b1, 1'b0, 1'b0, acc1);
    wait_idle();
    send(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, acc1);
    wait_idle();

    // Back-to-back: valid held high across the frame boundary.
    send(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, acc1);
    send(8'h80, 1'b0, 1'b0, 1'b0, 1'b0, acc2);
    check_eq("b2b_accept_in_done", 32'(acc2 - last_done_cyc), 32'd1);
    wait_idle();

    // A valid pulse during DATA must not disturb the running frame.
    send(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, acc1);
    step(BIT_T * 3);
    tx_valid = 1'b1;
    tx_data = 8'h3C;
    step(1);
    tx_valid = 1'b0;
    check_eq("ignored_ready_low", 32'(tx_ready), 32'd0);
    wait_idle();

    // Reset in the middle of DATA aborts without tx_done.
    send(8'hC5, 1'b1, 1'b0, 1'b1, 1'b0, acc1);
    step(BIT_T * 4);
    rst = 1'b0;
    aborted++;
    #1;
    check_eq("abort_out", 32'(tx_out), 32'd1);
    check_eq("abort_ready", 32'(tx_ready), 32'd1);
    check_eq("abort_busy", 32'(tx_busy), 32'd0);
    check_eq("abort_done", 32'(tx_done), 32'd0);
    step(4);
    rst = 1'b1;
    step(200);

    // Baud line frozen mid-bit for 1000 clk.
    send(8'h96, 1'b1, 1'b1, 1'b0, 1'b0, acc1);
    step(BIT_T * 5 + 17);
    baud_run = 1'b0;
    step(1000);
    baud_run = 1'b1;
    wait_idle();

    // Random frames with random gaps (some land while the previous frame runs).
    for (int i = 0; i < 8; i++) begin
      step($urandom_range(0, 300));
      send(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, acc1);
    end
    wait_idle();

    check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check_eq("frames_seen", 32'(frames_seen), 32'(sent - aborted));
    check_eq("final_ready", 32'(tx_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
